// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector lane sequencer and its lane ALUs.
package vec_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_VV   = 2'b01,
        OP_VS   = 2'b10,
        OP_RSVD = 2'b11
    } op_type_e;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Number of L-wide chunks needed to cover V elements.
    function automatic int nchunks(input int v, input int l);
        return (v + l - 1) / l;
    endfunction

endpackage

// File: rtl/lane_alu.sv
// Single combinational lane ALU: modulo-2^N add/sub and bitwise and/or.
module lane_alu
    import vec_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  alu_ctrl_e    ctrl_i,
    output logic [N-1:0] result_o
);

    always_comb begin
        unique case (ctrl_i)
            ADD:     result_o = a_i + b_i;
            SUB:     result_o = a_i - b_i;
            AND:     result_o = a_i & b_i;
            OR:      result_o = a_i | b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Vector execute unit: snapshots a V-element op, streams it through L lane ALUs one
// chunk per cycle, and writes each chunk's results back into the assembled result vector.
module vector_lane_sequencer
    import vec_pkg::*;
#(
    parameter int N = 32,
    parameter int V = 20,
    parameter int L = 4,
    localparam int NCH = nchunks(V, L),
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [1:0]          op_type_i,
    input  logic [1:0]          alu_ctrl_i,
    input  logic [V-1:0][N-1:0] vec_a_i,
    input  logic [V-1:0][N-1:0] vec_b_i,
    input  logic [N-1:0]        scalar_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [CW-1:0]       chunk_o,
    output logic [V-1:0][N-1:0] result_o
);

    // Element index width must cover the padded span NCH*L, not just V.
    localparam int EW = (NCH * L > 1) ? $clog2(NCH * L) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       chunk_q, chunk_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    op_type_e            op_q;
    alu_ctrl_e           ctrl_q;
    logic [V-1:0][N-1:0] a_q, b_q;
    logic [V-1:0][N-1:0] result_q;
    logic                accept;

    logic [EW-1:0] elem_idx [L];
    logic [L-1:0]  elem_valid;
    logic [N-1:0]  lane_a [L];
    logic [N-1:0]  lane_b [L];
    logic [N-1:0]  lane_alu_res [L];
    logic [N-1:0]  lane_res [L];

    assign accept = (state_q == IDLE) && start_i && (op_type_i != OP_RSVD);

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (op_type_i == OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        chunk_d = '0;
                    end
                end
            end
            RUN: begin
                if (chunk_q == LAST_CHUNK) begin
                    chunk_d = '0;
                    state_d = DONE;
                end else begin
                    chunk_d = chunk_q + CW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            chunk_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= OP_PASS;
            ctrl_q  <= ADD;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                a_q    <= vec_a_i;
                op_q   <= op_type_e'(op_type_i);
                ctrl_q <= alu_ctrl_e'(alu_ctrl_i);
                for (int e = 0; e < V; e++) begin
                    b_q[e] <= (op_type_i == OP_VS) ? scalar_i : vec_b_i[e];
                end
            end
        end
    end

    // Lanes past the end of the vector see zero operands and never write back.
    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_lane
            assign elem_idx[gi]   = EW'(chunk_q) * EW'(L) + EW'(gi);
            assign elem_valid[gi] = int'(elem_idx[gi]) < V;
            assign lane_a[gi]     = elem_valid[gi] ? a_q[elem_idx[gi]] : '0;
            assign lane_b[gi]     = elem_valid[gi] ? b_q[elem_idx[gi]] : '0;

            lane_alu #(.N(N)) u_lane_alu (
                .a_i      (lane_a[gi]),
                .b_i      (lane_b[gi]),
                .ctrl_i   (ctrl_q),
                .result_o (lane_alu_res[gi])
            );

            assign lane_res[gi] = (op_q == OP_PASS) ? lane_a[gi] : lane_alu_res[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (state_q == RUN) begin
            for (int l = 0; l < L; l++) begin
                if (elem_valid[l]) begin
                    result_q[elem_idx[l]] <= lane_res[l];
                end
            end
        end
    end

    assign busy_o   = (state_q == RUN);
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign chunk_o  = chunk_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Self-checking bench: two sequencer instances (V=20 and V=10, L=4) driven by directed
// and random ops, compared against a plain per-element arithmetic model.
module tb_vector_lane_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // V=20 instance (5 chunks)
    logic              start20;
    logic [1:0]        op20, ctrl20;
    logic [19:0][31:0] a20, b20, res20;
    logic [31:0]       sc20;
    logic              busy20, done20, err20;
    logic [2:0]        chunk20;

    // V=10 instance (3 chunks)
    logic              start10;
    logic [1:0]        op10, ctrl10;
    logic [9:0][31:0]  a10, b10, res10;
    logic [31:0]       sc10;
    logic              busy10, done10, err10;
    logic [1:0]        chunk10;

    vector_lane_sequencer #(.N(32), .V(20), .L(4)) dut20 (
        .clk(clk), .rst(rst), .start_i(start20), .op_type_i(op20), .alu_ctrl_i(ctrl20),
        .vec_a_i(a20), .vec_b_i(b20), .scalar_i(sc20), .busy_o(busy20), .done_o(done20),
        .err_o(err20), .chunk_o(chunk20), .result_o(res20)
    );

    vector_lane_sequencer #(.N(32), .V(10), .L(4)) dut10 (
        .clk(clk), .rst(rst), .start_i(start10), .op_type_i(op10), .alu_ctrl_i(ctrl10),
        .vec_a_i(a10), .vec_b_i(b10), .scalar_i(sc10), .busy_o(busy10), .done_o(done10),
        .err_o(err10), .chunk_o(chunk10), .result_o(res10)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [639:0] last_res [2];

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [639:0] model(input int sel, input logic [1:0] op, input logic [1:0] ctrl,
                                           input logic [639:0] a, input logic [639:0] b,
                                           input logic [31:0] sc);
        logic [639:0] r;
        logic [31:0]  x, y;
        int v;
        r = '0;
        v = (sel == 1) ? 10 : 20;
        for (int i = 0; i < v; i++) begin
            x = a[i*32 +: 32];
            y = (op == 2'b10) ? sc : b[i*32 +: 32];
            if (op == 2'b00) r[i*32 +: 32] = x;
            else begin
                case (ctrl)
                    2'b00:   r[i*32 +: 32] = x + y;
                    2'b01:   r[i*32 +: 32] = x - y;
                    2'b10:   r[i*32 +: 32] = x & y;
                    default: r[i*32 +: 32] = x | y;
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic obs_done(input int sel);
        return (sel == 1) ? done10 : done20;
    endfunction
    function automatic logic obs_busy(input int sel);
        return (sel == 1) ? busy10 : busy20;
    endfunction
    function automatic logic obs_err(input int sel);
        return (sel == 1) ? err10 : err20;
    endfunction
    function automatic logic [2:0] obs_chunk(input int sel);
        return (sel == 1) ? {1'b0, chunk10} : chunk20;
    endfunction
    function automatic logic [639:0] obs_res(input int sel);
        return (sel == 1) ? {320'b0, res10} : res20;
    endfunction

    task automatic drive(input int sel, input logic [1:0] op, input logic [1:0] ctrl,
                         input logic [639:0] a, input logic [639:0] b, input logic [31:0] sc);
        if (sel == 1) begin
            op10 = op; ctrl10 = ctrl; a10 = a[319:0]; b10 = b[319:0]; sc10 = sc;
        end else begin
            op20 = op; ctrl20 = ctrl; a20 = a; b20 = b; sc20 = sc;
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start10 = v;
        else start20 = v;
    endtask

    // Called at a negedge; launches immediately so consecutive calls exercise back-to-back.
    task automatic run_op(input int sel, input logic [1:0] op, input logic [1:0] ctrl,
                          input logic [639:0] a, input logic [639:0] b, input logic [31:0] sc,
                          input bit disturb);
        logic [639:0] exp;
        int nch, lat, busy_n;
        nch = (sel == 1) ? 3 : 5;
        exp = model(sel, op, ctrl, a, b, sc);
        drive(sel, op, ctrl, a, b, sc);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        if (op == 2'b11) begin
            check("err_pulse", obs_err(sel), 1);
            check("err_busy", obs_busy(sel), 0);
            @(negedge clk);
            check("err_clear", obs_err(sel), 0);
            check("err_idle", obs_busy(sel), 0);
            check("err_result_kept", obs_res(sel), last_res[sel]);
            return;
        end
        lat = 0;
        busy_n = 0;
        while (!obs_done(sel) && lat < 40) begin
            if (obs_busy(sel)) begin
                busy_n++;
                check("chunk_idx", obs_chunk(sel), lat % nch);
            end
            if (disturb && lat == 1) begin
                drive(sel, op, ctrl, ~a, ~b, ~sc);
                set_start(sel, 1'b1);
            end
            if (disturb && lat == 5) set_start(sel, 1'b0);
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, nch + 1);
        check("busy_cycles", busy_n, nch);
        check("no_err", obs_err(sel), 0);
        check("result", obs_res(sel), exp);
        last_res[sel] = exp;
    endtask

    initial begin
        logic [639:0] va, vb, vr;
        logic [31:0]  w;
        int           cnt;
        int           sel;

        rst = 1'b1;
        start20 = 1'b0; start10 = 1'b0;
        drive(0, 2'b00, 2'b00, '0, '0, '0);
        drive(1, 2'b00, 2'b00, '0, '0, '0);
        last_res[0] = '0;
        last_res[1] = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy20, 0);
        check("rst_done", done20, 0);
        check("rst_err", err20, 0);
        check("rst_chunk", chunk20, 0);
        check("rst_result", res20, 0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: A[i]=i, B[i]=2i, VV ADD
        for (int i = 0; i < 20; i++) begin
            va[i*32 +: 32] = 32'(i);
            vb[i*32 +: 32] = 32'(2 * i);
        end
        run_op(0, 2'b01, 2'b00, va, vb, 32'd0, 1'b0);
        w = res20[19];
        check("t1_elem19", w, 57);

        // Test 2 (back-to-back): VS SUB, scalar 3
        run_op(0, 2'b10, 2'b01, va, vb, 32'd3, 1'b0);
        w = res20[0];
        check("t2_elem0", w, 32'hFFFF_FFFD);
        w = res20[19];
        check("t2_elem19", w, 16);
        @(negedge clk);
        check("done_one_pulse", done20, 0);

        // Test 3: V=10, AND of constant patterns
        for (int i = 0; i < 20; i++) begin
            va[i*32 +: 32] = 32'hF0F0_F0F0;
            vb[i*32 +: 32] = 32'h0FF0_0FF0;
        end
        run_op(1, 2'b01, 2'b10, va, vb, 32'd0, 1'b0);
        w = res10[9];
        check("t3_elem9", w, 32'h00F0_00F0);

        // Test 4: operand change and stray start during RUN
        for (int i = 0; i < 20; i++) begin
            va[i*32 +: 32] = $urandom;
            vb[i*32 +: 32] = $urandom;
        end
        run_op(0, 2'b01, 2'b11, va, vb, 32'd0, 1'b1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done20) cnt++;
        end
        check("t4_single_done", cnt, 0);
        check("t4_stays_idle", busy20, 0);

        // Test 5: reset at chunk 2
        drive(0, 2'b01, 2'b00, va, vb, 32'd0);
        start20 = 1'b1;
        @(negedge clk);
        start20 = 1'b0;
        cnt = 0;
        while (chunk20 != 3'd2 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("t5_reach_chunk2", cnt, 2);
        rst = 1'b1;
        #1;
        check("t5_busy", busy20, 0);
        check("t5_done", done20, 0);
        check("t5_chunk", chunk20, 0);
        check("t5_result", res20, 0);
        last_res[0] = '0;
        last_res[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done20) cnt++;
        end
        check("t5_no_done", cnt, 0);
        run_op(0, 2'b01, 2'b01, va, vb, 32'd0, 1'b0);

        // Test 6: reserved op then pass-through
        @(negedge clk);
        run_op(0, 2'b11, 2'b00, ~va, ~vb, 32'd7, 1'b0);
        run_op(0, 2'b00, 2'b01, va, vb, 32'd9, 1'b0);
        vr = res20;
        check("t6_pass_eq_a", vr, va);

        // Random ops on both instances, including reserved op_type
        for (int k = 0; k < 14; k++) begin
            for (int i = 0; i < 20; i++) begin
                va[i*32 +: 32] = $urandom;
                vb[i*32 +: 32] = $urandom;
            end
            sel = (k % 3 == 0) ? 1 : 0;
            if (sel == 1) begin
                va[639:320] = '0;
                vb[639:320] = '0;
            end
            run_op(sel, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), va, vb, $urandom, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
